muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Multi-cycle multiply/divide sequencer for the pipelined MIPS core; owns the HI/LO registers used by MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Accepts one operation from EX, iterates a shift-add (multiply) or restoring-subtract (divide) datapath for DW cycles, sign-corrects the result, then writes HI/LO.
- Drives busy so the hazard logic stalls MFHI/MFLO and further mult/div ops until the result is committed.
- Sits beside the ALU in EX and never shares the ALU adder.

Parameters:
DW, 32, operand width; also the CALC iteration count.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  launch operation; sampled only in IDLE or DONE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  DW  rs operand (multiplicand / dividend)
b  in  DW  rt operand (multiplier / divisor)
cancel  in  1  pipeline flush; aborts an in-flight operation
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  DW  MTHI/MTLO data
busy  out  1  high in PREP, CALC, FIXUP
done  out  1  one-cycle pulse in DONE
hi  out  DW  HI register
lo  out  DW  LO register

Behaviour:
- Reset (async): state IDLE; hi=0, lo=0, busy=0, done=0; iteration counter=0; internal working registers cleared.
- States: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE/DONE + start: latch op, a, b; go to PREP. DONE without start goes to IDLE.
- PREP (1 cycle):
  - Signed ops: latch |a| and |b| as unsigned magnitudes; record result-sign and remainder-sign (dividend sign).
  - Divide with b==0: go directly to FIXUP with div0 flag set.
  - Otherwise: clear counter and go to CALC.
- CALC (exactly DW cycles):
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring step per cycle.
  - Counter increments each cycle; leave CALC when counter==DW-1.
- FIXUP (1 cycle):
  - Apply two's-complement negation per recorded signs.
  - Multiply: {hi,lo} = 2*DW-bit product.
  - Divide: lo = quotient, hi = remainder; remainder sign = dividend sign.
  - hi/lo are written at the FIXUP->DONE edge.
- Divide by zero (all ops): lo = all ones, hi = a (unmodified rs).
- DIV 0x80000000 / -1: lo = 0x80000000, hi = 0. This is the natural result of magnitude division; no special case.
- Latency: start sampled in cycle 0 -> done high and hi/lo valid in cycle DW+3 (35 for DW=32). Divide by zero: cycle 3.
- start while busy: ignored.
- cancel:
  - In PREP/CALC/FIXUP: next state IDLE; hi/lo unchanged; no done pulse.
  - cancel dominates start in the same cycle.
  - In IDLE/DONE: no effect except that it suppresses start.
- mthi/mtlo:
  - Honoured only when busy=0; ignored while busy.
  - If asserted in the same cycle as start (IDLE/DONE), the MT write takes effect and the operation still launches; its later result overwrites hi/lo.
- Reset mid-operation: immediate return to the reset values.

Decomposition:
- Shared package:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encoding: ST_IDLE, ST_PREP, ST_CALC, ST_FIXUP, ST_DONE.
  - DIV0_LO constant (all ones).
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Multiply mode: conditional add plus shift.
  - Divide mode: trial subtract plus restore, producing a quotient bit.
  - muldiv_seq keeps the state, counter, sign flags and HI/LO.

Test Plan:
- MULTU a=0xFFFFFFFF b=2 -> busy high in cycles 1..34; done in cycle 35; hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> done in cycle 3; lo=0xFFFFFFFF, hi=100. DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0 in cycle 35.
- MTHI 0x1234 then MULTU 6*7; cancel in cycle 10 -> state IDLE in cycle 11; hi=0x1234, lo unchanged; no done pulse.
- During CALC: start(DIVU 9/3) and mtlo(0xAA) pulses -> both ignored; original op completes with its own result. Then mtlo in DONE -> lo=0xAA next cycle.
- Assert reset in cycle 20 of a MULT -> busy=0, done=0, hi=lo=0 immediately, with no clock edge needed; a subsequent op completes normally.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_CALC  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned MaxDw = 64;
  // Sliced to the operand width by the user.
  localparam logic [MaxDw-1:0] DIV0_LO = '1;

  function automatic logic op_is_signed(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int unsigned DW = 32
) (
  input  logic          div_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  input  logic [DW-1:0] opnd_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  logic [DW:0]   sum;
  logic [DW:0]   shifted;
  logic [DW-1:0] sub;
  logic          ge;

  always_comb begin
    // Multiply: {hi,lo} holds {partial product, remaining multiplier bits}.
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: hi is the partial remainder, lo shifts the dividend out / quotient in.
    shifted = {hi_i, lo_i[DW-1]};
    sub     = shifted[DW-1:0] - opnd_i;
    ge      = shifted >= {1'b0, opnd_i};
    if (div_i) begin
      hi_o = ge ? sub : shifted[DW-1:0];
      lo_o = {lo_i[DW-2:0], ge};
    end else begin
      hi_o = sum[DW:1];
      lo_o = {sum[0], lo_i[DW-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO; iterates on magnitudes and
// sign-corrects in FIXUP.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cancel,
  input  logic          mthi,
  input  logic          mtlo,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DW - 1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [DW-1:0]   step_hi, step_lo;
  logic [DW-1:0]   mag_a, mag_b;
  logic [2*DW-1:0] prod;
  logic            is_signed, is_div;

  muldiv_step #(
    .DW (DW)
  ) u_step (
    .div_i  (is_div),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  always_comb begin
    is_signed = op_is_signed(op_q);
    is_div    = op_is_div(op_q);
    mag_a     = (is_signed && a_q[DW-1]) ? -a_q : a_q;
    mag_b     = (is_signed && b_q[DW-1]) ? -b_q : b_q;
    prod      = {acc_hi_q, acc_lo_q};
    if (neg_q) prod = -prod;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // MT writes land even when an op launches in the same cycle.
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        state_d = ST_IDLE;
        if (start && !cancel) begin
          state_d = ST_PREP;
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
        end
      end
      ST_PREP: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          neg_d     = is_signed && (a_q[DW-1] ^ b_q[DW-1]);
          rem_neg_d = is_signed && a_q[DW-1];
          div0_d    = is_div && (b_q == '0);
          acc_hi_d  = '0;
          acc_lo_d  = is_div ? mag_a : mag_b;
          opnd_d    = is_div ? mag_b : mag_a;
          cnt_d     = '0;
          state_d   = (is_div && (b_q == '0)) ? ST_FIXUP : ST_CALC;
        end
      end
      ST_CALC: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CntLast) state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          if (div0_q) begin
            lo_d = DIV0_LO[DW-1:0];
            hi_d = a_q;
          end else if (is_div) begin
            lo_d = neg_q ? -acc_lo_q : acc_lo_q;
            hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_PREP) || (state_q == ST_CALC) || (state_q == ST_FIXUP);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected {hi,lo} queued at launch, checked at done.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, cancel, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_seq #(
    .DW (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // Reference: 64-bit arithmetic on sign/zero-extended operands, {hi,lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sx, sy, p, q, r;
    sx = o[0] ? $signed({32'h0, x}) : $signed({{32{x[31]}}, x});
    sy = o[0] ? $signed({32'h0, y}) : $signed({{32{y[31]}}, y});
    if (!o[1]) begin
      p = sx * sy;
      return p;
    end
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // All tasks start and end 1ns after a rising edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat, output bit got);
    lat = from;
    got = done;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      got = done;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b, required 0 0", busy, done);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h, required 0 0", hi, lo);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_timing();
    logic [63:0] e;
    exp_q.push_back(64'h0000_0001_FFFF_FFFE);
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    for (int c = 1; c < 35; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL multu_busy cycle %0d: busy=%b done=%b, required 1 0", c, busy, done);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL multu_done cycle 35: busy=%b done=%b, required 0 1", busy, done);
    end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      errors++;
      $display("FAIL multu_result: got %h_%h, required %h", hi, lo, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_div_table();
    logic [1:0]  t_op  [10] = '{OP_MULT, OP_DIV, OP_DIV, OP_DIVU, OP_MULTU,
                                OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_MULT};
    logic [31:0] t_a   [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100,
                                32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF,
                                32'd5, 32'h0};
    logic [31:0] t_b   [10] = '{32'd5, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF,
                                32'h8000_0000, 32'hFFFF_FFFE, 32'h10, 32'd0,
                                32'hFFFF_FFFF};
    logic [63:0] t_exp [10] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFD,
                                64'h0000_0000_8000_0000, 64'h0000_0064_FFFF_FFFF,
                                64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000,
                                64'h0000_0001_FFFF_FFFD, 64'h0000_000F_0FFF_FFFF,
                                64'h0000_0005_FFFF_FFFF, 64'h0};
    int          t_lat [10] = '{35, 35, 35, 3, 35, 35, 35, 35, 3, 35};
    int lat;
    bit got;
    logic [63:0] e;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(t_exp[i]);
      launch(t_op[i], t_a[i], t_b[i]);
      wait_done(1, lat, got);
      checks++;
      if (!got || lat != t_lat[i]) begin
        errors++;
        $display("FAIL table_latency[%0d]: done in cycle %0d (seen=%0b), required %0d",
                 i, lat, got, t_lat[i]);
      end
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo} !== e) begin
        errors++;
        $display("FAIL table_result[%0d]: got %h_%h, required %h", i, hi, lo, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    int lat, want;
    bit got;
    logic [63:0] e;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 2) == 0) y = y & 32'hFF;
      want = (o[1] && y == 32'h0) ? 3 : 35;
      exp_q.push_back(model(o, x, y));
      launch(o, x, y);
      wait_done(1, lat, got);
      checks++;
      if (!got || lat != want) begin
        errors++;
        $display("FAIL random_latency[%0d]: done in cycle %0d, required %0d", i, lat, want);
      end
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo} !== e) begin
        errors++;
        $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h_%h, required %h",
                 i, o, x, y, hi, lo, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cancel();
    int pulses;
    wdata = 32'h5555; mtlo = 1'b1;
    @(posedge clk); #1;
    mtlo = 1'b0; wdata = 32'h1234; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5555) begin
      errors++;
      $display("FAIL mt_idle: hi=%h lo=%h, required 00001234 00005555", hi, lo);
    end
    launch(OP_MULTU, 32'd6, 32'd7);
    repeat (9) begin
      @(posedge clk); #1;
    end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle: busy=%b done=%b, required 0 0", busy, done);
    end
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5555) begin
      errors++;
      $display("FAIL cancel_hilo: hi=%h lo=%h, required 00001234 00005555", hi, lo);
    end
    pulses = 0;
    repeat (40) begin
      if (done === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL cancel_no_done: %0d done pulses, required 0", pulses);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    bit got;
    logic [63:0] e;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
    mtlo = 1'b1; wdata = 32'hAA;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    checks++;
    if (lo !== 32'h5555 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore_mt: lo=%h busy=%b, required 00005555 1", lo, busy);
    end
    wait_done(6, lat, got);
    checks++;
    if (!got || lat != 35) begin
      errors++;
      $display("FAIL busy_ignore_latency: done in cycle %0d, required 35", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      errors++;
      $display("FAIL busy_ignore_result: got %h_%h, required %h", hi, lo, e);
    end
    mtlo = 1'b1; wdata = 32'hAA;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++;
    if (lo !== 32'hAA || hi !== 32'hFFFF_FFFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_in_done: hi=%h lo=%h busy=%b, required ffffffff 000000aa 0",
               hi, lo, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit got;
    logic [63:0] e;
    exp_q.push_back(64'h0000_0006_0000_008E);
    launch(OP_DIVU, 32'd1000, 32'd7);
    wait_done(1, lat, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || {hi, lo} !== e) begin
      errors++;
      $display("FAIL b2b_first: got %h_%h (seen=%0b), required %h", hi, lo, got, e);
    end
    // Launch from DONE with a simultaneous MTHI.
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF4);
    mthi = 1'b1; wdata = 32'hBEEF;
    launch(OP_MULT, 32'd3, 32'hFFFF_FFFC);
    mthi = 1'b0;
    checks++;
    if (busy !== 1'b1 || hi !== 32'hBEEF) begin
      errors++;
      $display("FAIL b2b_launch_mt: busy=%b hi=%h, required 1 0000beef", busy, hi);
    end
    wait_done(1, lat, got);
    checks++;
    if (!got || lat != 35) begin
      errors++;
      $display("FAIL b2b_latency: done in cycle %0d, required 35", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      errors++;
      $display("FAIL b2b_second: got %h_%h, required %h", hi, lo, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit got;
    logic [63:0] e;
    launch(OP_MULT, 32'h0001_2345, 32'h0000_0678);
    repeat (19) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0",
               busy, done, hi, lo);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(64'h0000_0002_0000_000E);
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(1, lat, got);
    checks++;
    if (!got || lat != 35) begin
      errors++;
      $display("FAIL after_reset_latency: done in cycle %0d, required 35", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      errors++;
      $display("FAIL after_reset_result: got %h_%h, required %h", hi, lo, e);
    end
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_mul_div_table();
    test_random();
    test_cancel();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
